tdm_mux_4_1: RTL and testbench
==============================

# tdm_mux_4_1

- Sequential 4-to-1 time-division multiplexer: captures a 4-bit parallel word and serialises it one lane per slot onto a single data line, with a matching 2-bit slot select.
- It is the transmit-side counterpart of `demux_1_4`. `Y` drives `demux_1_4.I` and `S` drives `demux_1_4.S` directly, so lane `k` appears on `demux_1_4.Y[k]` during slot `k`.
- Frames run back-to-back while enabled. The current frame always completes before the block idles.

## Interface
- `HOLD`, default 1: cycles each slot is held; legal range 1..256.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset; release is synchronous to `clk`.
- `en` input 1: request frame transmission; sampled at frame boundaries only.
- `D` input 4: parallel lane data; sampled only at frame capture.
- `Y` output 1: serial data, equal to the captured lane selected by `S`.
- `S` output 2: current slot index.
- `busy` output 1: high while a frame is in progress.
- `frame_start` output 1: single-cycle pulse on the first cycle of each frame.

## Operation
- **Reset values:** state IDLE, `Y`=0, `S`=0, `busy`=0, `frame_start`=0, shadow register=0, hold counter=0.
- **IDLE:** outputs at reset values. A rising edge with `en`=1 performs these actions:
  - shadow <= `D`, `S` <= 0, hold counter <= 0, state <= RUN, `frame_start` <= 1.
- **RUN, hold counter:** increments every cycle.
  - When it equals `HOLD`-1 it wraps to 0 and `S` advances by 1.
- **RUN, frame end:** the slot-3 wrap (`S`=3 and hold counter = `HOLD`-1).
  - `en`=1: recapture `D` into shadow, `S` <= 0, `frame_start` <= 1, stay in RUN. There is no idle gap.
  - `en`=0: state <= IDLE, `S` <= 0.
- **`en` deassert mid-frame:** ignored; the frame completes.
- **`D` changes mid-frame:** ignored; only the shadow copy is transmitted.
- **Output derivation:** `Y` = shadow[`S`] when `busy`, else 0. `busy` = (state == RUN).
  - All outputs are decoded from registers only. There is no combinational path from `D` or `en` to any output.
- **Reset asserted mid-frame:** all registers clear immediately. After release the block sits in IDLE until `en` is sampled high; no partial frame resumes.
- **Counter width:** hold counter is max(1, $clog2(`HOLD`)) bits; `S` wraps 3 to 0 modulo 4.

## Timing
- **Capture latency:** capture happens at edge k (IDLE, `en`=1). After edge k: `busy`=1, `frame_start`=1, `S`=0, `Y`=D_k[0].
- **Frame length:** exactly 4·`HOLD` cycles. Slot j occupies cycles 1 + j·`HOLD` .. (j+1)·`HOLD` after capture.
- **`frame_start`:** high for exactly one cycle, coincident with the first cycle of slot 0. It never asserts while `S`≠0.
- **Return to idle:** at the final edge of the last frame, `busy` falls and `S` is already 0.
- **Re-entry from IDLE:** `en` still high one cycle later starts a new frame.
- **`HOLD`=1:** `S` changes every cycle (0,1,2,3,0,...), and `frame_start` pulses every 4th cycle while `en`=1.

## Structure
- **Shared package `tdm_pkg`:**
  - `NUM_SLOTS`=4.
  - `SEL_W`=2.
  - State enum {`ST_IDLE`, `ST_RUN`}.
  - Shared with any future TDM receive-side wrapper around `demux_1_4`.
- **Sub-module `tdm_slot_timer`:** hold counter plus slot counter.
  - Inputs: `clk`, `rst_n`, `run`, `restart`.
  - Outputs: `S`, `slot_last` (`S`=3 and hold counter = `HOLD`-1).
- **Top level:** FSM, shadow register and output decode.

## Test plan
- **Reset values:** assert `rst_n`=0 with `en`=1 and `D`=4'b1111 → `Y`=0, `S`=0, `busy`=0, `frame_start`=0 throughout reset.
- **Single frame, `HOLD`=1:** `D`=4'b1010, `en` high for 1 cycle → over 4 cycles `S`=0,1,2,3 and `Y`=0,1,0,1. `frame_start` high only in the first cycle. `busy` high for exactly 4 cycles, then IDLE.
- **Back-to-back, `HOLD`=1:** `en` held high, `D`=4'b0110 then changed to 4'b1001 mid-frame.
  - First frame: `Y`=0,1,1,0.
  - Second frame, no gap: `Y`=1,0,0,1.
  - `frame_start` pulses every 4 cycles.
- **`HOLD`=3:** `D`=4'b1100, single request → `S` holds each value 3 cycles (0,0,0,1,1,1,...) and `Y`=0,0,0,0,0,0,1,1,1,1,1,1. `busy` high for 12 cycles.
- **Mid-frame `en` drop:** deassert `en` in slot 1 → frame still completes through slot 3, then `busy`=0 and `S`=0.
- **Reset mid-frame:** pulse `rst_n` low asynchronously (between edges) during slot 2 → outputs clear immediately, without waiting for a clock edge. With `en`=0 after release the block stays IDLE. Raising `en` starts a fresh frame at `S`=0 carrying newly captured `D`.
- **Pass/fail:** a loopback through `demux_1_4` checks `Y[k]` against the captured lane in every scenario.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: definitions shared by the TDM transmit block and any future
// receive-side wrapper around demux_1_4.
//   NUM_SLOTS   : lanes per frame
//   SEL_W       : slot-select width
//   tdm_state_e : frame sequencing state
package tdm_pkg;
   localparam int NUM_SLOTS = 4;
   localparam int SEL_W     = 2;

   typedef enum logic {ST_IDLE, ST_RUN} tdm_state_e;
endpackage

// File: rtl/tdm_slot_timer.sv
// tdm_slot_timer: per-slot hold counter plus slot index counter.
//   clk, rst_n : clock, async active-low reset
//   run        : frame in progress; counters are held at zero otherwise
//   restart    : force both counters to zero (start of a new frame)
//   S          : current slot index
//   slot_last  : last cycle of the last slot (S = NUM_SLOTS-1, hold = HOLD-1)
module tdm_slot_timer
   import tdm_pkg::*;
#(
   parameter int HOLD = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             restart,
   output logic [SEL_W-1:0] S,
   output logic             slot_last
);
   localparam int                CNT_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(HOLD - 1);
   localparam logic [SEL_W-1:0]  S_LAST  = SEL_W'(NUM_SLOTS - 1);

   logic [CNT_W-1:0] cnt;
   logic             hold_done;

   assign hold_done = (cnt == CNT_MAX);
   assign slot_last = hold_done && (S == S_LAST);

   // S wraps naturally from the last slot to 0, which is also where a
   // back-to-back frame has to begin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         S   <= '0;
      end else if (restart || !run) begin
         cnt <= '0;
         S   <= '0;
      end else if (hold_done) begin
         cnt <= '0;
         S   <= S + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/tdm_mux_4_1.sv
// tdm_mux_4_1: captures a 4-bit word and serialises it one lane per slot.
//   clk, rst_n  : clock, async active-low reset
//   en          : frame request, sampled at frame boundaries only
//   D           : parallel lane data, sampled only at capture
//   Y           : serial data (captured lane selected by S, 0 when idle)
//   S           : slot index, drives the receiver's select directly
//   busy        : frame in progress
//   frame_start : one-cycle pulse on the first cycle of every frame
module tdm_mux_4_1
   import tdm_pkg::*;
#(
   parameter int HOLD = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [NUM_SLOTS-1:0] D,
   output logic                 Y,
   output logic [SEL_W-1:0]     S,
   output logic                 busy,
   output logic                 frame_start
);
   tdm_state_e           state_q, state_d;
   logic [NUM_SLOTS-1:0] shadow;
   logic                 capture;
   logic                 slot_last;

   tdm_slot_timer #(.HOLD(HOLD)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (busy),
      .restart   (capture),
      .S         (S),
      .slot_last (slot_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shadow      <= '0;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_start <= capture;
         if (capture) shadow <= D;
      end
   end

   // en is only looked at in IDLE or on the final cycle of a frame, so a
   // mid-frame deassert never truncates the frame in flight.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               capture = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (slot_last) begin
               if (en) capture = 1'b1;
               else    state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs come from registers only; no path from D or en.
   assign busy = (state_q == ST_RUN);
   assign Y    = busy ? shadow[S] : 1'b0;
endmodule

// File: tb/tb_tdm_mux_4_1.sv
module tb_tdm_mux_4_1;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en1 = 1'b0, en3 = 1'b0;
   logic [3:0] d1 = '0, d3 = '0;
   logic       y1, y3, busy1, busy3, fs1, fs3;
   logic [1:0] s1, s3;

   int checks = 0;
   int errors = 0;
   int sel    = 1;
   string scn = "init";
   logic [8:0] sb_q[$];

   always #5 clk = ~clk;

   tdm_mux_4_1 #(.HOLD(1)) u_h1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .D(d1),
      .Y(y1), .S(s1), .busy(busy1), .frame_start(fs1)
   );

   tdm_mux_4_1 #(.HOLD(3)) u_h3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .D(d3),
      .Y(y3), .S(s3), .busy(busy3), .frame_start(fs3)
   );

   // receive side: demux_1_4 behaviour, Y routed to lane S
   logic [3:0] dmx1, dmx3;
   always_comb begin
      dmx1 = '0;
      dmx3 = '0;
      dmx1[s1] = y1;
      dmx3[s3] = y3;
   end

   // observation word: {frame_start, busy, S, Y, demux lanes}
   logic [8:0] obs1, obs3;
   assign obs1 = {fs1, busy1, s1, y1, dmx1};
   assign obs3 = {fs3, busy3, s3, y3, dmx3};

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got fs/busy/S/Y/lanes=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                  tag, got[8], got[7], got[6:5], got[4], got[3:0],
                  exp[8], exp[7], exp[6:5], exp[4], exp[3:0]);
      end
   endtask

   // expected frame built straight from the timing description
   task automatic push_frame(input int hold, input logic [3:0] d);
      for (int j = 0; j < 4; j++)
         for (int h = 0; h < hold; h++) begin
            logic [3:0] lanes;
            lanes    = '0;
            lanes[j] = d[j];
            sb_q.push_back({(j == 0 && h == 0), 1'b1, 2'(j), d[j], lanes});
         end
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) sb_q.push_back(9'b0);
   endtask

   task automatic step();
      logic [8:0] e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk($sformatf("%s@%0d", scn, checks), (sel == 1) ? obs1 : obs3, e);
      end
   endtask

   initial begin
      // reset held with en high and all-ones data: both units must stay idle
      scn = "reset";
      en1 = 1'b1; en3 = 1'b1; d1 = 4'b1111; d3 = 4'b1111;
      #1;
      chk("reset_h1_t0", obs1, 9'b0);
      chk("reset_h3_t0", obs3, 9'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("reset_h1", obs1, 9'b0);
         chk("reset_h3", obs3, 9'b0);
      end
      en1 = 1'b0; en3 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // HOLD=1 single frame
      sel = 1; scn = "h1_single";
      push_idle(1); step();
      en1 = 1'b1; d1 = 4'b1010;
      push_frame(1, 4'b1010);
      step();
      en1 = 1'b0; d1 = 4'b0000;
      repeat (3) step();
      push_idle(2); repeat (2) step();

      // HOLD=1 back-to-back, D changes mid-frame
      scn = "h1_b2b";
      en1 = 1'b1; d1 = 4'b0110;
      push_frame(1, 4'b0110);
      push_frame(1, 4'b1001);
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 0) d1 = 4'b1001;
         if (i == 4) begin en1 = 1'b0; d1 = 4'b0000; end
      end
      push_idle(2); repeat (2) step();

      // HOLD=3 single frame
      sel = 3; scn = "h3_single";
      en3 = 1'b1; d3 = 4'b1100;
      push_frame(3, 4'b1100);
      step();
      en3 = 1'b0; d3 = 4'b0011;
      repeat (11) step();
      push_idle(2); repeat (2) step();

      // HOLD=3, en held into slot 1 then dropped
      scn = "h3_endrop";
      en3 = 1'b1; d3 = 4'b0101;
      push_frame(3, 4'b0101);
      for (int i = 0; i < 12; i++) begin
         step();
         if (i == 3) en3 = 1'b0;
      end
      push_idle(3); repeat (3) step();

      // HOLD=3, async reset in slot 2
      scn = "h3_rst";
      en3 = 1'b1; d3 = 4'b0111;
      push_frame(3, 4'b0111);
      step();
      en3 = 1'b0;
      repeat (6) step();
      chk("h3_rst_pre_slot2", obs3, {1'b0, 1'b1, 2'd2, 1'b1, 4'b0100});
      sb_q.delete();
      #2;
      rst_n = 1'b0;
      #1;
      chk("h3_rst_async_clear", obs3, 9'b0);
      #4;
      rst_n = 1'b1;
      push_idle(3); repeat (3) step();
      en3 = 1'b1; d3 = 4'b1011;
      push_frame(3, 4'b1011);
      step();
      en3 = 1'b0;
      repeat (11) step();
      push_idle(2); repeat (2) step();

      if (sb_q.size() != 0) chk("sb_drain", 9'(sb_q.size()), 9'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
